register_file: RTL and testbench

Architectural integer register file for the pipelined ARM core: 32 entries of WIDTH bits, one synchronous write port (writeback stage) and two combinational read ports (decode stage). Entry 31 is the zero register (XZR). A write-to-read bypass makes writeback data visible to decode in the same cycle. A pending-write scoreboard flags read operands whose producer has issued but not yet written back; the hazard unit uses these flags to stall decode.

---
 rtl/regfile_pkg.sv | 6 +
 rtl/register_scoreboard.sv | 34 +++
 rtl/register_file.sv | 46 ++++
 tb/tb_register_file.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-address types for decode, hazard unit and writeback
package regfile_pkg;
   localparam int ADDR_W = 5;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   localparam reg_addr_t XZR = 5'd31;
endpackage

// File: rtl/register_scoreboard.sv
// register_scoreboard: pending-write bitmap with issue-over-writeback priority and decode hazard flags
module register_scoreboard
   import regfile_pkg::*;
#(
   parameter int        NREGS    = 32,
   parameter reg_addr_t ZERO_REG = XZR
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      wr_en,
   input  reg_addr_t wr_addr,
   input  logic      issue_en,
   input  reg_addr_t issue_addr,
   input  reg_addr_t rd_addr1,
   input  reg_addr_t rd_addr2,
   output logic      hazard1,
   output logic      hazard2
);
   logic [NREGS-1:0] pending, set_mask, clr_mask;
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_en && issue_addr != ZERO_REG) set_mask[issue_addr] = 1'b1;
      if (wr_en && wr_addr != ZERO_REG) clr_mask[wr_addr] = 1'b1;
   end
   // OR-ing the set after the clear lets a newer producer win over a same-cycle writeback
   always_ff @(posedge clk or negedge reset)
      if (!reset) pending <= '0;
      else        pending <= (pending & ~clr_mask) | set_mask;
   always_comb begin
      hazard1 = pending[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
      hazard2 = pending[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
   end
endmodule

// File: rtl/register_file.sv
// register_file: 32-entry integer register file with XZR, write-to-read bypass and pending-write scoreboard
module register_file
   import regfile_pkg::*;
#(
   parameter int        WIDTH    = 64,
   parameter int        NREGS    = 32,
   parameter reg_addr_t ZERO_REG = XZR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  reg_addr_t        wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  reg_addr_t        rd_addr1,
   input  reg_addr_t        rd_addr2,
   output logic [WIDTH-1:0] rd_data1,
   output logic [WIDTH-1:0] rd_data2,
   input  logic             issue_en,
   input  reg_addr_t        issue_addr,
   output logic             hazard1,
   output logic             hazard2
);
   logic [WIDTH-1:0] mem [NREGS];
   always_ff @(posedge clk or negedge reset)
      if (!reset)                             mem <= '{default: '0};
      else if (wr_en && wr_addr != ZERO_REG)  mem[wr_addr] <= wr_data;
   // reset gating keeps the bypass from leaking wr_data while reset is held
   always_comb begin
      rd_data1 = (!reset || rd_addr1 == ZERO_REG) ? '0 :
                 (wr_en && wr_addr == rd_addr1)   ? wr_data : mem[rd_addr1];
      rd_data2 = (!reset || rd_addr2 == ZERO_REG) ? '0 :
                 (wr_en && wr_addr == rd_addr2)   ? wr_data : mem[rd_addr2];
   end
   register_scoreboard #(.NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_sb (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .hazard1    (hazard1),
      .hazard2    (hazard2)
   );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scoreboard-queue bench for register_file
module tb_register_file;
   import regfile_pkg::*;
   localparam int RD1 = 0, RD2 = 1, HZ1 = 2, HZ2 = 3;
   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] v;
   } exp_t;
   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en, issue_en, hazard1, hazard2;
   reg_addr_t   wr_addr, rd_addr1, rd_addr2, issue_addr;
   logic [63:0] wr_data, rd_data1, rd_data2;
   logic [31:0] bpend;
   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   register_file dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .rd_data1   (rd_data1),
      .rd_data2   (rd_data2),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .hazard1    (hazard1),
      .hazard2    (hazard2)
   );
   task automatic expect_val(input string tag, input int sel, input logic [63:0] v);
      q.push_back('{tag, sel, v});
   endtask
   task automatic check();
      exp_t        e;
      logic [63:0] obs;
      while (q.size() > 0) begin
         e = q.pop_front();
         obs = e.sel == RD1 ? rd_data1 : e.sel == RD2 ? rd_data2 :
               e.sel == HZ1 ? {63'd0, hazard1} : {63'd0, hazard2};
         checks++;
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // drives one cycle of inputs; checks the one-producer-per-register pipeline rule and tracks pending bits
   task automatic drive(input logic we, input reg_addr_t wa, input logic [63:0] wd,
                        input logic ie, input reg_addr_t ia, input reg_addr_t a1, input reg_addr_t a2);
      wr_en = we; wr_addr = wa; wr_data = wd;
      issue_en = ie; issue_addr = ia; rd_addr1 = a1; rd_addr2 = a2;
      if (reset && ie && ia != XZR) begin
         checks++;
         assert (!(bpend[ia] && !(we && wa == ia))) else begin
            errors++;
            $error("FAIL double_issue observed=%0d expected=0", ia);
         end
      end
      if (reset) begin
         if (we && wa != XZR) bpend[wa] = 1'b0;
         if (ie && ia != XZR) bpend[ia] = 1'b1;
      end
   endtask
   initial begin
      bpend = '0;
      reset = 1'b0;
      drive(1, 5, 64'hAA, 1, 5, 5, 5);
      expect_val("rst_rd1", RD1, 0);
      expect_val("rst_rd2", RD2, 0);
      expect_val("rst_hz1", HZ1, 0);
      @(negedge clk); check();
      cyc();
      expect_val("rst_hold_rd1", RD1, 0);
      expect_val("rst_hold_hz1", HZ1, 0);
      @(negedge clk); check();
      cyc(); reset = 1'b1;
      drive(0, 0, 0, 0, 0, 5, 5);
      expect_val("post_rst_x5", RD1, 0);
      expect_val("post_rst_hz1", HZ1, 0);
      @(negedge clk); check();
      cyc(); drive(1, 5, 64'hDEAD, 0, 0, 5, 0);
      expect_val("x5_bypass", RD1, 64'hDEAD);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 0, 0, 5, 0);
      expect_val("x5_stored", RD1, 64'hDEAD);
      @(negedge clk); check();
      #2 reset = 1'b0; bpend = '0;
      #1 expect_val("async_rst_x5", RD1, 0);
      check();
      cyc(); reset = 1'b1;
      expect_val("x5_after_rst", RD1, 0);
      @(negedge clk); check();
      cyc(); drive(1, 3, 64'h1234, 0, 0, 3, 0);
      expect_val("x3_bypass", RD1, 64'h1234);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 0, 0, 3, 0);
      expect_val("x3_stored", RD1, 64'h1234);
      @(negedge clk); check();
      cyc(); drive(1, 31, 64'hFFFF, 1, 31, 0, 31);
      expect_val("xzr_wr_rd2", RD2, 0);
      expect_val("xzr_wr_hz2", HZ2, 0);
      @(negedge clk); check();
      for (int i = 0; i < 2; i++) begin
         cyc(); drive(0, 0, 0, 0, 0, 0, 31);
         expect_val("xzr_rd2", RD2, 0);
         expect_val("xzr_hz2", HZ2, 0);
         @(negedge clk); check();
      end
      cyc(); drive(0, 0, 0, 1, 7, 7, 0);
      expect_val("x7_issue_hz1", HZ1, 0);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 0, 0, 7, 0);
      expect_val("x7_pending_hz1", HZ1, 1);
      @(negedge clk); check();
      cyc(); drive(1, 7, 64'h42, 0, 0, 7, 0);
      expect_val("x7_wb_hz1", HZ1, 0);
      expect_val("x7_wb_rd1", RD1, 64'h42);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 0, 0, 7, 0);
      expect_val("x7_done_hz1", HZ1, 0);
      expect_val("x7_done_rd1", RD1, 64'h42);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 1, 9, 9, 0);
      @(negedge clk);
      cyc(); drive(1, 9, 64'h11, 1, 9, 9, 0);
      expect_val("x9_setclr_hz1", HZ1, 0);
      expect_val("x9_setclr_rd1", RD1, 64'h11);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 0, 0, 9, 0);
      expect_val("x9_set_wins_hz1", HZ1, 1);
      expect_val("x9_set_wins_rd1", RD1, 64'h11);
      @(negedge clk); check();
      cyc(); drive(1, 9, 64'h22, 0, 0, 9, 0);
      @(negedge clk);
      cyc(); drive(0, 0, 0, 0, 0, 9, 0);
      expect_val("x9_clear_hz1", HZ1, 0);
      expect_val("x9_clear_rd1", RD1, 64'h22);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 1, 1, 1, 2);
      @(negedge clk);
      cyc(); drive(1, 1, 64'h5, 1, 2, 1, 2);
      expect_val("x1_wb_hz1", HZ1, 0);
      expect_val("x2_issue_hz2", HZ2, 0);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 0, 0, 1, 2);
      expect_val("x1_cleared_hz1", HZ1, 0);
      expect_val("x2_pending_hz2", HZ2, 1);
      expect_val("x1_rd1", RD1, 64'h5);
      @(negedge clk); check();
      cyc(); drive(1, 2, 64'h6, 0, 0, 1, 2);
      expect_val("x2_wb_hz2", HZ2, 0);
      expect_val("x2_wb_rd2", RD2, 64'h6);
      @(negedge clk); check();
      cyc(); drive(0, 0, 0, 0, 0, 3, 2);
      expect_val("x2_done_hz2", HZ2, 0);
      expect_val("x3_final_rd1", RD1, 64'h1234);
      expect_val("x2_final_rd2", RD2, 64'h6);
      @(negedge clk); check();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
